// File: rtl/mips_enc_pkg.sv
// mips_enc_pkg: shared op enumeration and opcode/funct tables for the SCCPU
// instruction subset. The same numbers are decoded by the control unit, so
// encoder and decoder stay in step by construction.
// Contents: op_e (symbolic op), kind_e (R/I/J format), OPC_* opcodes,
// FN_* functs, is_legal() helper.
package mips_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_ADDU = 5'd6,  OP_SUBU = 5'd7,
    OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SLLV = 5'd10, OP_SRLV = 5'd11,
    OP_NOR  = 5'd12, OP_JR   = 5'd13, OP_JALR = 5'd14, OP_ADDI = 5'd15,
    OP_ORI  = 5'd16, OP_LW   = 5'd17, OP_SW   = 5'd18, OP_BEQ  = 5'd19,
    OP_BNE  = 5'd20, OP_SLTI = 5'd21, OP_LUI  = 5'd22, OP_ANDI = 5'd23,
    OP_J    = 5'd24, OP_JAL  = 5'd25
  } op_e;

  typedef enum logic [1:0] {K_R, K_I, K_J} kind_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic is_legal(input logic [4:0] op);
    return op <= 5'd25;
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if: symbolic-instruction input channel and encoded-word
// output channel of the encoder.
//   master: program-loader / IMEM side (drives in_*, out_ready)
//   slave : encoder (drives in_ready, out_valid, out_word, out_addr)
// AW is the byte-address width of out_addr.
interface mips_instr_encoder_if #(parameter int unsigned AW = 10);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_op;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [4:0]    in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    output out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    input  out_ready,
    output in_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/mips_enc_pack.sv
// mips_enc_pack: combinational op + fields -> 32-bit machine word.
// Fields the op does not use are forced to zero in the word.
// Macro ENC_FIELD_CHECK_EN: when defined, field_err_o flags any nonzero
// unused field on a legal op; otherwise field_err_o is tied 0.
// Ports: op_i, rs_i, rt_i, rd_i, shamt_i, imm_i, target_i in;
//        word_o (encoded word), legal_o (op 0..25), field_err_o out.
import mips_enc_pkg::*;

module mips_enc_pack (
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o,
  output logic        field_err_o
);

  kind_e      kind;
  logic [5:0] opc;
  logic [5:0] fn;
  logic       use_rs, use_rt, use_rd, use_sh, use_imm, use_tgt;

  assign legal_o = is_legal(op_i);

  always_comb begin
    kind    = K_R;
    opc     = OPC_RTYPE;
    fn      = 6'h00;
    case (op_e'(op_i))
      OP_ADD:  fn = FN_ADD;
      OP_SUB:  fn = FN_SUB;
      OP_AND:  fn = FN_AND;
      OP_OR:   fn = FN_OR;
      OP_SLT:  fn = FN_SLT;
      OP_SLTU: fn = FN_SLTU;
      OP_ADDU: fn = FN_ADDU;
      OP_SUBU: fn = FN_SUBU;
      OP_SLL:  fn = FN_SLL;
      OP_SRL:  fn = FN_SRL;
      OP_SLLV: fn = FN_SLLV;
      OP_SRLV: fn = FN_SRLV;
      OP_NOR:  fn = FN_NOR;
      OP_JR:   fn = FN_JR;
      OP_JALR: fn = FN_JALR;
      OP_ADDI: begin kind = K_I; opc = OPC_ADDI; end
      OP_ORI:  begin kind = K_I; opc = OPC_ORI;  end
      OP_LW:   begin kind = K_I; opc = OPC_LW;   end
      OP_SW:   begin kind = K_I; opc = OPC_SW;   end
      OP_BEQ:  begin kind = K_I; opc = OPC_BEQ;  end
      OP_BNE:  begin kind = K_I; opc = OPC_BNE;  end
      OP_SLTI: begin kind = K_I; opc = OPC_SLTI; end
      OP_LUI:  begin kind = K_I; opc = OPC_LUI;  end
      OP_ANDI: begin kind = K_I; opc = OPC_ANDI; end
      OP_J:    begin kind = K_J; opc = OPC_J;    end
      OP_JAL:  begin kind = K_J; opc = OPC_JAL;  end
      default: ;
    endcase
  end

  // Field usage per format; an illegal op uses nothing, so its word is 0.
  always_comb begin
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    use_rd  = 1'b0;
    use_sh  = 1'b0;
    use_imm = 1'b0;
    use_tgt = 1'b0;
    if (legal_o) begin
      case (kind)
        K_R: begin
          use_sh = (op_i == OP_SLL) || (op_i == OP_SRL);
          use_rs = !use_sh;
          use_rt = (op_i != OP_JR) && (op_i != OP_JALR);
          use_rd = (op_i != OP_JR);
        end
        K_I: begin
          use_rs  = (op_i != OP_LUI);
          use_rt  = 1'b1;
          use_imm = 1'b1;
        end
        default: use_tgt = 1'b1;
      endcase
    end
  end

  logic [4:0]  rs_m, rt_m, rd_m, sh_m;
  logic [15:0] imm_m;
  logic [25:0] tgt_m;

  assign rs_m  = use_rs  ? rs_i     : 5'd0;
  assign rt_m  = use_rt  ? rt_i     : 5'd0;
  assign rd_m  = use_rd  ? rd_i     : 5'd0;
  assign sh_m  = use_sh  ? shamt_i  : 5'd0;
  assign imm_m = use_imm ? imm_i    : 16'd0;
  assign tgt_m = use_tgt ? target_i : 26'd0;

  always_comb begin
    case (kind)
      K_I:     word_o = {opc, rs_m, rt_m, imm_m};
      K_J:     word_o = {opc, tgt_m};
      default: word_o = {OPC_RTYPE, rs_m, rt_m, rd_m, sh_m, fn};
    endcase
  end

`ifdef ENC_FIELD_CHECK_EN
  assign field_err_o = legal_o & (
      ((|rs_i)     & ~use_rs)  | ((|rt_i)   & ~use_rt)  |
      ((|rd_i)     & ~use_rd)  | ((|shamt_i) & ~use_sh) |
      ((|imm_i)    & ~use_imm) | ((|target_i) & ~use_tgt));
`else
  assign field_err_o = 1'b0;
`endif

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: accepts symbolic instructions, encodes them and streams
// {word, byte address} toward the IMEM write port with one cycle of latency.
// Ports: clk, rstn (sync, active low), start (restart at BASE_ADDR),
//        bus (slave modport: in_* channel and out_* channel),
//        enc_count, full, err_illegal, err_field (status).
// err_field only ever sets when ENC_FIELD_CHECK_EN is defined (see mips_enc_pack).
import mips_enc_pkg::*;

module mips_instr_encoder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AW        = $clog2(DEPTH) + 2,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  mips_instr_encoder_if.slave  bus,
  output logic [AW-1:0]        enc_count,
  output logic                 full,
  output logic                 err_illegal,
  output logic                 err_field
);

  logic [31:0]   enc_word;
  logic          legal, field_err, accept;

  logic          out_valid_q, out_valid_d;
  logic [31:0]   word_q, word_d;
  logic [AW-1:0] oaddr_q, oaddr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          err_ill_q, err_ill_d;
  logic          err_fld_q, err_fld_d;

  mips_enc_pack u_pack (
    .op_i        (bus.in_op),
    .rs_i        (bus.in_rs),
    .rt_i        (bus.in_rt),
    .rd_i        (bus.in_rd),
    .shamt_i     (bus.in_shamt),
    .imm_i       (bus.in_imm),
    .target_i    (bus.in_target),
    .word_o      (enc_word),
    .legal_o     (legal),
    .field_err_o (field_err)
  );

  // A slot opens when the output register is empty or is draining this cycle.
  assign bus.in_ready = rstn & ~start & ~full_q & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    word_d      = word_q;
    oaddr_d     = oaddr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    full_d      = full_q;
    err_ill_d   = err_ill_q;
    err_fld_d   = err_fld_q;
    if (start) begin
      out_valid_d = 1'b0;
      addr_d      = AW'(BASE_ADDR);
      count_d     = '0;
      full_d      = 1'b0;
      err_ill_d   = 1'b0;
      err_fld_d   = 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
      if (accept) begin
        if (legal) begin
          out_valid_d = 1'b1;
          word_d      = enc_word;
          oaddr_d     = addr_q;
          addr_d      = addr_q + AW'(4);
          count_d     = count_q + AW'(1);
          if (count_q == AW'(DEPTH - 1)) full_d = 1'b1;
          if (field_err) err_fld_d = 1'b1;
        end else begin
          err_ill_d = 1'b1;  // dropped: no word, no address advance
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      word_q      <= '0;
      oaddr_q     <= '0;
      addr_q      <= AW'(BASE_ADDR);
      count_q     <= '0;
      full_q      <= 1'b0;
      err_ill_q   <= 1'b0;
      err_fld_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      word_q      <= word_d;
      oaddr_q     <= oaddr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_ill_q   <= err_ill_d;
      err_fld_q   <= err_fld_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = word_q;
  assign bus.out_addr  = oaddr_q;
  assign enc_count     = count_q;
  assign full          = full_q;
  assign err_illegal   = err_ill_q;
  assign err_field     = err_fld_q;

endmodule
